// File: rtl/branch_predict_resolve_if.sv
// Bundle between the IF PC mux / EX/MEM register (master) and the branch
// predict/resolve block (slave).
interface branch_predict_resolve_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] If_pc;
  logic              Pred_taken;
  logic [ADDR_W-1:0] Pred_target;
  logic              Exmem_valid;
  logic              Exmem_branch;
  logic [2:0]        Exmem_condition;
  logic [ADDR_W-1:0] Exmem_pc;
  logic [ADDR_W-1:0] Exmem_pc_4;
  logic [ADDR_W-1:0] Exmem_target;
  logic              Exmem_lf;
  logic              Exmem_zf;
  logic              Exmem_pred_taken;
  logic [ADDR_W-1:0] Exmem_pred_target;
  logic [ADDR_W-1:0] Final_target;
  logic              Redirect;
  logic [ADDR_W-1:0] Redirect_pc;
  logic [31:0]       Branch_count;
  logic [31:0]       Mispredict_count;

  modport master (
    output If_pc, Exmem_valid, Exmem_branch, Exmem_condition, Exmem_pc,
           Exmem_pc_4, Exmem_target, Exmem_lf, Exmem_zf, Exmem_pred_taken,
           Exmem_pred_target,
    input  Pred_taken, Pred_target, Final_target, Redirect, Redirect_pc,
           Branch_count, Mispredict_count
  );

  modport slave (
    input  If_pc, Exmem_valid, Exmem_branch, Exmem_condition, Exmem_pc,
           Exmem_pc_4, Exmem_target, Exmem_lf, Exmem_zf, Exmem_pred_taken,
           Exmem_pred_target,
    output Pred_taken, Pred_target, Final_target, Redirect, Redirect_pc,
           Branch_count, Mispredict_count
  );
endinterface

// File: rtl/branch_predict_resolve.sv
// EX/MEM branch resolution with an IF-stage BTB of saturating counters,
// mispredict redirect and saturating branch/mispredict performance counters.
module branch_predict_resolve #(
  parameter int ADDR_W      = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int CNT_W       = 2
) (
  input logic                   clk,
  input logic                   rst,
  branch_predict_resolve_if.slave bus
);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_NE     = 3'b010;
  localparam logic [2:0] COND_GE     = 3'b011;
  localparam logic [2:0] COND_GT     = 3'b100;
  localparam logic [2:0] COND_LE     = 3'b101;
  localparam logic [2:0] COND_LT     = 3'b110;
  localparam logic [2:0] COND_SKIP   = 3'b111;

  localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] WEAK_NT = WEAK_T - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      PERF_MAX = 32'hFFFF_FFFF;

  logic              btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
  logic [ADDR_W-1:0] btb_target [BTB_ENTRIES];
  logic [CNT_W-1:0]  btb_cnt    [BTB_ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic              cond_true;
  logic              is_cond_branch;
  logic              taken;
  logic [ADDR_W-1:0] final_target;
  logic [ADDR_W-1:0] pred_next;
  logic              redirect;
  logic              update_en;
  logic [31:0]       branch_cnt;
  logic [31:0]       mispredict_cnt;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^{bus.If_pc[1:0], bus.Exmem_pc[1:0]};

  // Fetch-side lookup sees the table as it stood before this cycle's update.
  assign lk_idx = bus.If_pc[IDX_W+1:2];
  assign lk_tag = bus.If_pc[ADDR_W-1:IDX_W+2];
  assign lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);

  assign bus.Pred_taken  = lk_hit && btb_cnt[lk_idx][CNT_W-1];
  assign bus.Pred_target = bus.Pred_taken ? btb_target[lk_idx]
                                          : bus.If_pc + ADDR_W'(4);

  assign up_idx = bus.Exmem_pc[IDX_W+1:2];
  assign up_tag = bus.Exmem_pc[ADDR_W-1:IDX_W+2];
  assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

  always_comb begin
    cond_true = 1'b0;
    case (bus.Exmem_condition)
      COND_ALWAYS: cond_true = 1'b1;
      COND_EQ:     cond_true = bus.Exmem_zf;
      COND_NE:     cond_true = !bus.Exmem_zf;
      COND_GE:     cond_true = !bus.Exmem_lf;
      COND_GT:     cond_true = !bus.Exmem_zf && !bus.Exmem_lf;
      COND_LE:     cond_true = bus.Exmem_zf || bus.Exmem_lf;
      COND_LT:     cond_true = bus.Exmem_lf;
      default:     cond_true = 1'b0;
    endcase
  end

  assign is_cond_branch = bus.Exmem_branch && (bus.Exmem_condition != COND_SKIP);
  assign taken          = is_cond_branch && cond_true;

  always_comb begin
    final_target = bus.Exmem_pc_4;
    if (bus.Exmem_branch) begin
      if (bus.Exmem_condition == COND_SKIP)
        final_target = bus.Exmem_pc_4 + ADDR_W'(4);
      else if (cond_true)
        final_target = bus.Exmem_target;
    end
  end

  assign pred_next = bus.Exmem_pred_taken ? bus.Exmem_pred_target : bus.Exmem_pc_4;
  assign redirect  = bus.Exmem_valid && !rst && (final_target != pred_next);
  assign update_en = bus.Exmem_valid && !rst;

  assign bus.Final_target = final_target;
  assign bus.Redirect     = redirect;
  assign bus.Redirect_pc  = final_target;

  // Valid bits and counters reset; a non-branch hitting an entry is an alias.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_cnt[i]   <= WEAK_NT;
      end
    end else if (bus.Exmem_valid) begin
      if (is_cond_branch) begin
        if (up_hit) begin
          if (taken) begin
            if (btb_cnt[up_idx] != CNT_MAX)
              btb_cnt[up_idx] <= btb_cnt[up_idx] + CNT_W'(1);
          end else if (btb_cnt[up_idx] != '0) begin
            btb_cnt[up_idx] <= btb_cnt[up_idx] - CNT_W'(1);
          end
        end else if (taken) begin
          btb_valid[up_idx] <= 1'b1;
          btb_cnt[up_idx]   <= WEAK_T;
        end
      end else if (!bus.Exmem_branch && up_hit) begin
        btb_valid[up_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (update_en && taken) begin
      btb_tag[up_idx]    <= up_tag;
      btb_target[up_idx] <= bus.Exmem_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (bus.Exmem_valid && bus.Exmem_branch && branch_cnt != PERF_MAX)
        branch_cnt <= branch_cnt + 32'd1;
      if (redirect && mispredict_cnt != PERF_MAX)
        mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

  assign bus.Branch_count     = branch_cnt;
  assign bus.Mispredict_count = mispredict_cnt;
endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: resolution, BTB training,
// aliasing, wrap, counter saturation and reset behaviour.
module tb_branch_predict_resolve;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  branch_predict_resolve_if #(.ADDR_W(32)) bus ();

  branch_predict_resolve #(
    .ADDR_W(32), .BTB_ENTRIES(16), .IDX_W(4), .CNT_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.Exmem_valid       = 1'b0;
    bus.Exmem_branch      = 1'b0;
    bus.Exmem_condition   = 3'b000;
    bus.Exmem_pc          = 32'h0;
    bus.Exmem_pc_4        = 32'h4;
    bus.Exmem_target      = 32'h0;
    bus.Exmem_lf          = 1'b0;
    bus.Exmem_zf          = 1'b0;
    bus.Exmem_pred_taken  = 1'b0;
    bus.Exmem_pred_target = 32'h0;
  endtask

  task automatic drive_exmem(input logic br, input logic [2:0] cond,
                             input logic [31:0] pc, input logic [31:0] tgt,
                             input logic lf, input logic zf,
                             input logic ptaken, input logic [31:0] ptarget);
    bus.Exmem_valid       = 1'b1;
    bus.Exmem_branch      = br;
    bus.Exmem_condition   = cond;
    bus.Exmem_pc          = pc;
    bus.Exmem_pc_4        = pc + 32'd4;
    bus.Exmem_target      = tgt;
    bus.Exmem_lf          = lf;
    bus.Exmem_zf          = zf;
    bus.Exmem_pred_taken  = ptaken;
    bus.Exmem_pred_target = ptarget;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.If_pc = 32'h100;
    drive_exmem(1'b1, 3'b000, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0, 32'h104);
    step();
    step();
    #1;
    tests++; if (bus.Redirect !== 1'b0) begin fails++; $display("[TB] FAIL rst_redirect got %0b want 0", bus.Redirect); end
    tests++; if (bus.Final_target !== 32'h200) begin fails++; $display("[TB] FAIL rst_final got %h want 00000200", bus.Final_target); end
    tests++; if (bus.Pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL rst_pred_taken got %0b want 0", bus.Pred_taken); end
    rst = 1'b0;
    drive_idle();
    #1;
    tests++; if (bus.Pred_target !== 32'h104) begin fails++; $display("[TB] FAIL rst_pred_target got %h want 00000104", bus.Pred_target); end
    tests++; if (bus.Redirect !== 1'b0) begin fails++; $display("[TB] FAIL idle_redirect got %0b want 0", bus.Redirect); end
    step();
    tests++; if (bus.Branch_count !== 32'd0) begin fails++; $display("[TB] FAIL rst_branch_count got %0d want 0", bus.Branch_count); end
    tests++; if (bus.Mispredict_count !== 32'd0) begin fails++; $display("[TB] FAIL rst_mispredict_count got %0d want 0", bus.Mispredict_count); end
  endtask

  task automatic test_taken_alloc();
    bus.If_pc = 32'h100;
    drive_exmem(1'b1, 3'b000, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0, 32'h104);
    #1;
    tests++; if (bus.Final_target !== 32'h200) begin fails++; $display("[TB] FAIL alloc_final got %h want 00000200", bus.Final_target); end
    tests++; if (bus.Redirect !== 1'b1) begin fails++; $display("[TB] FAIL alloc_redirect got %0b want 1", bus.Redirect); end
    tests++; if (bus.Redirect_pc !== 32'h200) begin fails++; $display("[TB] FAIL alloc_redirect_pc got %h want 00000200", bus.Redirect_pc); end
    tests++; if (bus.Pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL alloc_same_cycle_lookup got %0b want 0", bus.Pred_taken); end
    step();
    drive_idle();
    #1;
    tests++; if (bus.Pred_taken !== 1'b1) begin fails++; $display("[TB] FAIL alloc_pred_taken got %0b want 1", bus.Pred_taken); end
    tests++; if (bus.Pred_target !== 32'h200) begin fails++; $display("[TB] FAIL alloc_pred_target got %h want 00000200", bus.Pred_target); end
    tests++; if (bus.Mispredict_count !== 32'd1) begin fails++; $display("[TB] FAIL alloc_mispredict_count got %0d want 1", bus.Mispredict_count); end
    tests++; if (bus.Branch_count !== 32'd1) begin fails++; $display("[TB] FAIL alloc_branch_count got %0d want 1", bus.Branch_count); end
  endtask

  task automatic test_not_taken();
    drive_exmem(1'b1, 3'b001, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1, 32'h200);
    #1;
    tests++; if (bus.Final_target !== 32'h104) begin fails++; $display("[TB] FAIL nt_final got %h want 00000104", bus.Final_target); end
    tests++; if (bus.Redirect !== 1'b1) begin fails++; $display("[TB] FAIL nt_redirect got %0b want 1", bus.Redirect); end
    step();
    drive_idle();
    #1;
    tests++; if (bus.Pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL nt_pred_taken got %0b want 0", bus.Pred_taken); end
    tests++; if (bus.Pred_target !== 32'h104) begin fails++; $display("[TB] FAIL nt_pred_target got %h want 00000104", bus.Pred_target); end
    tests++; if (bus.Mispredict_count !== 32'd2) begin fails++; $display("[TB] FAIL nt_mispredict_count got %0d want 2", bus.Mispredict_count); end
  endtask

  task automatic test_correct_predict();
    drive_exmem(1'b1, 3'b010, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1, 32'h200);
    #1;
    tests++; if (bus.Final_target !== 32'h200) begin fails++; $display("[TB] FAIL cp_final got %h want 00000200", bus.Final_target); end
    tests++; if (bus.Redirect !== 1'b0) begin fails++; $display("[TB] FAIL cp_redirect got %0b want 0", bus.Redirect); end
    step();
    drive_idle();
    #1;
    tests++; if (bus.Pred_taken !== 1'b1) begin fails++; $display("[TB] FAIL cp_pred_taken got %0b want 1", bus.Pred_taken); end
    tests++; if (bus.Branch_count !== 32'd3) begin fails++; $display("[TB] FAIL cp_branch_count got %0d want 3", bus.Branch_count); end
    tests++; if (bus.Mispredict_count !== 32'd2) begin fails++; $display("[TB] FAIL cp_mispredict_count got %0d want 2", bus.Mispredict_count); end
  endtask

  task automatic test_conditions();
    logic        vbr   [14] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,0};
    logic [2:0]  vcond [14] = '{3'b011,3'b011,3'b100,3'b100,3'b100,3'b101,3'b101,
                                3'b101,3'b110,3'b110,3'b001,3'b010,3'b111,3'b000};
    logic        vlf   [14] = '{0,1,0,1,0,0,1,0,1,0,0,0,1,0};
    logic        vzf   [14] = '{0,0,0,0,1,1,0,0,0,1,1,1,1,0};
    logic [31:0] vexp  [14] = '{32'h400,32'h304,32'h400,32'h304,32'h304,32'h400,32'h400,
                                32'h304,32'h400,32'h304,32'h400,32'h304,32'h308,32'h304};
    for (int i = 0; i < 14; i++) begin
      drive_exmem(vbr[i], vcond[i], 32'h300, 32'h400, vlf[i], vzf[i], 1'b0, 32'h0);
      bus.Exmem_valid = 1'b0;
      #1;
      tests++; if (bus.Final_target !== vexp[i]) begin fails++; $display("[TB] FAIL cond_final[%0d] got %h want %h", i, bus.Final_target, vexp[i]); end
      tests++; if (bus.Redirect !== 1'b0) begin fails++; $display("[TB] FAIL cond_invalid_redirect[%0d] got %0b want 0", i, bus.Redirect); end
    end
    step();
    drive_idle();
    tests++; if (bus.Branch_count !== 32'd3) begin fails++; $display("[TB] FAIL cond_branch_count got %0d want 3", bus.Branch_count); end
  endtask

  task automatic test_skip_wrap();
    bus.If_pc = 32'h0FFF_FFF8;
    drive_exmem(1'b1, 3'b111, 32'h0FFF_FFF8, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0FFF_FFFC);
    #1;
    tests++; if (bus.Final_target !== 32'h1000_0000) begin fails++; $display("[TB] FAIL skip_final got %h want 10000000", bus.Final_target); end
    tests++; if (bus.Redirect !== 1'b1) begin fails++; $display("[TB] FAIL skip_redirect got %0b want 1", bus.Redirect); end
    step();
    tests++; if (bus.Pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL skip_no_alloc got %0b want 0", bus.Pred_taken); end
    drive_exmem(1'b1, 3'b111, 32'hFFFF_FFF8, 32'h500, 1'b0, 1'b0, 1'b1, 32'h0);
    bus.If_pc = 32'hFFFF_FFF8;
    #1;
    tests++; if (bus.Final_target !== 32'h0) begin fails++; $display("[TB] FAIL wrap_final got %h want 00000000", bus.Final_target); end
    tests++; if (bus.Redirect !== 1'b0) begin fails++; $display("[TB] FAIL wrap_redirect got %0b want 0", bus.Redirect); end
    step();
    drive_idle();
    #1;
    tests++; if (bus.Pred_target !== 32'hFFFF_FFFC) begin fails++; $display("[TB] FAIL wrap_pred_target got %h want fffffffc", bus.Pred_target); end
    tests++; if (bus.Branch_count !== 32'd5) begin fails++; $display("[TB] FAIL skip_branch_count got %0d want 5", bus.Branch_count); end
    tests++; if (bus.Mispredict_count !== 32'd3) begin fails++; $display("[TB] FAIL skip_mispredict_count got %0d want 3", bus.Mispredict_count); end
    bus.If_pc = 32'h100;
    #1;
    tests++; if (bus.Pred_target !== 32'h200) begin fails++; $display("[TB] FAIL skip_entry_kept got %h want 00000200", bus.Pred_target); end
  endtask

  task automatic test_alias();
    bus.If_pc = 32'h140;
    #1;
    tests++; if (bus.Pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL alias_tag_miss got %0b want 0", bus.Pred_taken); end
    tests++; if (bus.Pred_target !== 32'h144) begin fails++; $display("[TB] FAIL alias_pred_target got %h want 00000144", bus.Pred_target); end
    drive_exmem(1'b0, 3'b000, 32'h100, 32'h999, 1'b0, 1'b0, 1'b1, 32'h200);
    #1;
    tests++; if (bus.Redirect !== 1'b1) begin fails++; $display("[TB] FAIL alias_redirect got %0b want 1", bus.Redirect); end
    tests++; if (bus.Redirect_pc !== 32'h104) begin fails++; $display("[TB] FAIL alias_redirect_pc got %h want 00000104", bus.Redirect_pc); end
    step();
    drive_idle();
    bus.If_pc = 32'h100;
    #1;
    tests++; if (bus.Pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL alias_invalidated got %0b want 0", bus.Pred_taken); end
    tests++; if (bus.Branch_count !== 32'd5) begin fails++; $display("[TB] FAIL alias_branch_count got %0d want 5", bus.Branch_count); end
    tests++; if (bus.Mispredict_count !== 32'd4) begin fails++; $display("[TB] FAIL alias_mispredict_count got %0d want 4", bus.Mispredict_count); end
    drive_exmem(1'b1, 3'b001, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0, 32'h104);
    #1;
    tests++; if (bus.Redirect !== 1'b0) begin fails++; $display("[TB] FAIL miss_nt_redirect got %0b want 0", bus.Redirect); end
    step();
    drive_idle();
    #1;
    tests++; if (bus.Pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL miss_nt_no_alloc got %0b want 0", bus.Pred_taken); end
  endtask

  task automatic test_counter_sat();
    logic [2:0] scond [9] = '{3'b000,3'b000,3'b000,3'b001,3'b001,3'b001,3'b001,3'b000,3'b000};
    logic       spred [9] = '{1,1,1,1,0,0,0,0,1};
    bus.If_pc = 32'h208;
    for (int i = 0; i < 9; i++) begin
      drive_exmem(1'b1, scond[i], 32'h208, 32'h600, 1'b0, 1'b0, 1'b0, 32'h20C);
      step();
      drive_idle();
      #1;
      tests++; if (bus.Pred_taken !== spred[i]) begin fails++; $display("[TB] FAIL sat_step[%0d] got %0b want %0b", i, bus.Pred_taken, spred[i]); end
    end
    tests++; if (bus.Pred_target !== 32'h600) begin fails++; $display("[TB] FAIL sat_pred_target got %h want 00000600", bus.Pred_target); end
    tests++; if (bus.Branch_count !== 32'd15) begin fails++; $display("[TB] FAIL sat_branch_count got %0d want 15", bus.Branch_count); end
    tests++; if (bus.Mispredict_count !== 32'd9) begin fails++; $display("[TB] FAIL sat_mispredict_count got %0d want 9", bus.Mispredict_count); end
  endtask

  task automatic test_mispredict_sat();
    force dut.mispredict_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.mispredict_cnt;
    drive_exmem(1'b1, 3'b000, 32'h700, 32'h800, 1'b0, 1'b0, 1'b0, 32'h704);
    step();
    tests++; if (bus.Mispredict_count !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL perf_reach_max got %h want ffffffff", bus.Mispredict_count); end
    tests++; if (bus.Redirect !== 1'b1) begin fails++; $display("[TB] FAIL perf_redirect got %0b want 1", bus.Redirect); end
    step();
    drive_idle();
    tests++; if (bus.Mispredict_count !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL perf_hold_max got %h want ffffffff", bus.Mispredict_count); end
    tests++; if (bus.Branch_count !== 32'd17) begin fails++; $display("[TB] FAIL perf_branch_count got %0d want 17", bus.Branch_count); end
  endtask

  task automatic test_reset_mid_update();
    bus.If_pc = 32'h308;
    drive_exmem(1'b1, 3'b000, 32'h308, 32'h900, 1'b0, 1'b0, 1'b0, 32'h30C);
    step();
    tests++; if (bus.Pred_taken !== 1'b1) begin fails++; $display("[TB] FAIL pre_rst_alloc got %0b want 1", bus.Pred_taken); end
    rst = 1'b1;
    drive_exmem(1'b1, 3'b000, 32'h40C, 32'hA00, 1'b0, 1'b0, 1'b0, 32'h410);
    #1;
    tests++; if (bus.Redirect !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_redirect got %0b want 0", bus.Redirect); end
    step();
    rst = 1'b0;
    drive_idle();
    #1;
    tests++; if (bus.Branch_count !== 32'd0) begin fails++; $display("[TB] FAIL mid_rst_branch_count got %0d want 0", bus.Branch_count); end
    tests++; if (bus.Mispredict_count !== 32'd0) begin fails++; $display("[TB] FAIL mid_rst_mispredict_count got %0d want 0", bus.Mispredict_count); end
    tests++; if (bus.Pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_entry_cleared got %0b want 0", bus.Pred_taken); end
    bus.If_pc = 32'h40C;
    #1;
    tests++; if (bus.Pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_update_dropped got %0b want 0", bus.Pred_taken); end
    bus.If_pc = 32'h700;
    #1;
    tests++; if (bus.Pred_taken !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_other_cleared got %0b want 0", bus.Pred_taken); end
    step();
    tests++; if (bus.Branch_count !== 32'd0) begin fails++; $display("[TB] FAIL post_rst_branch_count got %0d want 0", bus.Branch_count); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.If_pc = 32'h0;
    drive_idle();
    test_reset();
    test_taken_alloc();
    test_not_taken();
    test_correct_predict();
    test_conditions();
    test_skip_wrap();
    test_alias();
    test_counter_sat();
    test_mispredict_sat();
    test_reset_mid_update();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
